// File: rtl/keypad_scan_ctrl.sv
// Column-scanning controller for a 4x4 hex keypad: synchronizes rows, debounces
// press and release, and emits one key code strobe per press plus a two-digit history.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV       = 12000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int RELEASE_TICKS  = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old,
    output logic       busy
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int RW = $clog2(RELEASE_TICKS + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [RW-1:0]   rcnt_q, rcnt_d;
    logic [3:0]      rs_meta_q, rs_meta_d;
    logic [3:0]      rs_q, rs_d;
    logic [3:0]      cols_q, cols_d;
    logic [3:0]      row_sel_q, row_sel_d;
    logic [3:0]      key_sel_q, key_sel_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic [3:0]      digit_new_q, digit_new_d;
    logic [3:0]      digit_old_q, digit_old_d;
    logic            busy_q, busy_d;

    logic            tick;
    logic            rs_onehot;
    logic            row_hit;
    logic            row_other;
    logic [1:0]      row_idx;
    logic [1:0]      col_idx;
    logic            accept;
    logic [3:0]      accept_sel;
    logic [3:0]      cols_rot;

    // Sel is {row index, column index}; the table is the physical keypad legend.
    function automatic logic [3:0] decode_key(input logic [3:0] sel);
        logic [3:0] k;
        case (sel)
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    always_comb begin
        tick      = (cnt_q == CW'(SCAN_DIV - 1));
        rs_onehot = (rs_q != 4'd0) && ((rs_q & (rs_q - 4'd1)) == 4'd0);
        row_hit   = (rs_q & row_sel_q) != 4'd0;
        row_other = (rs_q & ~row_sel_q) != 4'd0;
        cols_rot  = {cols_q[2:0], cols_q[3]};

        case (rs_q)
            4'b0010: row_idx = 2'd1;
            4'b0100: row_idx = 2'd2;
            4'b1000: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
        case (cols_q)
            4'b0010: col_idx = 2'd1;
            4'b0100: col_idx = 2'd2;
            4'b1000: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase

        state_d     = state_q;
        cnt_d       = tick ? '0 : cnt_q + CW'(1);
        dcnt_d      = dcnt_q;
        rcnt_d      = rcnt_q;
        rs_meta_d   = rows;
        rs_d        = rs_meta_q;
        cols_d      = cols_q;
        row_sel_d   = row_sel_q;
        key_sel_d   = key_sel_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        digit_new_d = digit_new_q;
        digit_old_d = digit_old_q;
        accept      = 1'b0;
        accept_sel  = key_sel_q;

        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (rs_onehot) begin
                        row_sel_d  = rs_q;
                        key_sel_d  = {row_idx, col_idx};
                        dcnt_d     = DW'(1);
                        accept_sel = {row_idx, col_idx};
                        accept     = (DEBOUNCE_TICKS == 1);
                        state_d    = DEBOUNCE;
                    end else begin
                        cols_d = cols_rot;
                    end
                end
                DEBOUNCE: begin
                    if (row_hit && !row_other) begin
                        dcnt_d = dcnt_q + DW'(1);
                        accept = (dcnt_q + DW'(1) == DW'(DEBOUNCE_TICKS));
                    end else begin
                        dcnt_d  = '0;
                        cols_d  = cols_rot;
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (!row_hit) begin
                        rcnt_d = RW'(1);
                        if (RELEASE_TICKS == 1) begin
                            cols_d  = cols_rot;
                            state_d = SCAN;
                        end else begin
                            state_d = RELEASE;
                        end
                    end
                end
                default: begin
                    if (!row_hit) begin
                        rcnt_d = rcnt_q + RW'(1);
                        if (rcnt_q + RW'(1) == RW'(RELEASE_TICKS)) begin
                            cols_d  = cols_rot;
                            state_d = SCAN;
                        end
                    end else begin
                        rcnt_d  = '0;
                        state_d = HELD;
                    end
                end
            endcase
        end

        // Acceptance shifts the display history and fires the single strobe.
        if (accept) begin
            key_code_d  = decode_key(accept_sel);
            key_valid_d = 1'b1;
            digit_old_d = digit_new_q;
            digit_new_d = decode_key(accept_sel);
            state_d     = HELD;
        end

        busy_d = (state_d != SCAN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SCAN;
            cnt_q       <= '0;
            dcnt_q      <= '0;
            rcnt_q      <= '0;
            rs_meta_q   <= '0;
            rs_q        <= '0;
            cols_q      <= 4'b0001;
            row_sel_q   <= '0;
            key_sel_q   <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            digit_new_q <= '0;
            digit_old_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dcnt_q      <= dcnt_d;
            rcnt_q      <= rcnt_d;
            rs_meta_q   <= rs_meta_d;
            rs_q        <= rs_d;
            cols_q      <= cols_d;
            row_sel_q   <= row_sel_d;
            key_sel_q   <= key_sel_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            digit_new_q <= digit_new_d;
            digit_old_q <= digit_old_d;
            busy_q      <= busy_d;
        end
    end

    assign cols      = cols_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign digit_new = digit_new_q;
    assign digit_old = digit_old_q;
    assign busy      = busy_q;

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Top-level sequencer for the 4x4 hex keypad. It generates the column scan tick, drives the one-hot column lines, synchronizes the row inputs, and debounces a press and its release. Each press produces exactly one registered key code and strobe. It also keeps a two-digit history for the dual seven-segment display driver.

## Interface

Parameters:
- SCAN_DIV, 12000: clk cycles per scan tick; legal range >= 4.
- DEBOUNCE_TICKS, 20: consecutive matching ticks needed to accept a press; >= 1.
- RELEASE_TICKS, 20: consecutive all-released ticks needed to accept a release; >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rows  in  4  raw keypad rows, active-high, asynchronous to clk.
- cols  out  4  one-hot column drive, active-high.
- key_code  out  4  hex value of the last accepted key.
- key_valid  out  1  one-cycle strobe when key_code updates.
- digit_new  out  4  most recent key, for the right display digit.
- digit_old  out  4  previous key, for the left display digit.
- busy  out  1  high in every state except SCAN.

## Operation

- rows pass through a 2-flop synchronizer; all decisions use the synchronized value rs.
- Tick counter counts 0..SCAN_DIV-1 and wraps. tick = (count == SCAN_DIV-1). The FSM evaluates only on tick cycles and holds otherwise.
- Key map, row i / col j: row0 = 1 2 3 A; row1 = 4 5 6 B; row2 = 7 8 9 C; row3 = E 0 F D.
- SCAN state:
  - If rs == 0 on tick, rotate cols left (0001->0010->0100->1000->0001).
  - If rs is exactly one-hot on tick, latch the row bit and the current column, set dcnt=1, go DEBOUNCE. cols freeze.
  - If rs has multiple bits set, treat it as rs == 0: keep rotating.
- DEBOUNCE state, on each tick:
  - If the latched row bit is high and no other row bit is high, dcnt++.
  - Otherwise go SCAN; cols rotate on that tick.
  - When dcnt reaches DEBOUNCE_TICKS, do all of the following at once and go HELD:
    - key_code <= decoded key.
    - key_valid <= 1 for one cycle.
    - digit_old <= digit_new, digit_new <= decoded key.
- HELD state: cols stay frozen.
  - On a tick with the latched row bit low, set rcnt=1 and go RELEASE.
  - Other rows and other columns are ignored; no second strobe is issued.
- RELEASE state, on each tick:
  - Latched row bit low: rcnt++.
  - Latched row bit high: go HELD, rcnt cleared.
  - When rcnt reaches RELEASE_TICKS, go SCAN. cols advance one position on the same edge.
- DEBOUNCE_TICKS=1 means acceptance happens on the detection tick itself. RELEASE_TICKS=1 behaves likewise for release.
- Reset values: state SCAN, cols 0001, key_code 0, key_valid 0, digit_new 0, digit_old 0, busy 0. Tick counter, dcnt, rcnt and synchronizer flops are all 0.
- Reset asserted mid-operation forces the reset values immediately, without waiting for a clock edge. After release the block resumes from SCAN with cols 0001.

## Timing

- All outputs are registered.
- cols changes only on the clk edge following a tick.
- Sampling margin: rows are sampled SCAN_DIV cycles after a column change, well beyond the 2-cycle synchronizer plus line settling.
- key_valid rises on the edge after the accepting tick and falls on the next edge. key_code and digits update on the same edge as the key_valid rise.
- Press latency is 2 clk + DEBOUNCE_TICKS x SCAN_DIV from the first stable row assertion, plus at most one scan revolution to reach the key's column.
- busy goes high on the edge after the detection tick. It goes low on the edge after the final release tick.

## Test plan

Bench parameters: SCAN_DIV=4, DEBOUNCE_TICKS=3, RELEASE_TICKS=2. The keypad model asserts rows[i] only when cols[j] is high for each pressed key (i,j).

- Reset, no keys -> outputs at reset values; cols steps 0001, 0010, 0100, 1000, 0001, one step every 4 cycles; key_valid never high.
- Hold '5' (row1,col1) -> exactly one key_valid pulse; key_code=5, digit_new=5, digit_old=0; cols frozen at 0010 while held, busy=1.
- Bounce on '9': row2 high for 2 ticks, then low -> no key_valid; busy returns to 0; scanning resumes from 0100.
- While holding '5':
  - Press '9' as well -> no strobe.
  - Drop row1 for 1 tick, then reassert -> returns to HELD, no strobe.
  - Release both -> SCAN after 2 ticks, cols=0100.
- Press/release '1', then 'D' -> two strobes; final digit_old=1, digit_new=D, key_code=D.
- Two rows high in col0 at once -> ignored, cols keep rotating.
- Drop reset low mid-HELD, between clock edges -> cols=0001, busy=0, digits=0 immediately.
